cpu_mem_responder: RTL and testbench
====================================

# cpu_mem_responder

Memory-side responder that terminates both the instruction and the data request/response channels driven by the multi-cycle RISC-V core. It holds a single word-organised RAM and serves instruction reads and data reads and writes with programmable latency. Byte-strobe writes are supported. Every response is held until the core acknowledges it. It is used as the simulation and FPGA memory model behind the core and sits directly on the core's channel ports.

## Interface
- ADDR_WIDTH, 12: word-address bits. RAM has 2^ADDR_WIDTH 32-bit words. Byte address bits [ADDR_WIDTH+1:2] index the RAM; higher bits are ignored, so addresses wrap.
- INST_LATENCY, 2: cycles from instruction-request handshake to Inst_Valid. Must be at least 1.
- DATA_LATENCY, 2: cycles from read-request handshake to Read_data_Valid. Must be at least 1.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- PC  in  32  instruction byte address; bits [1:0] ignored.
- Inst_Req_Valid  in  1  instruction request valid.
- Inst_Req_Ready  out  1  instruction request accepted this cycle if valid.
- Instruction  out  32  instruction word.
- Inst_Valid  out  1  instruction response valid.
- Inst_Ready  in  1  core accepts the instruction response.
- Address  in  32  data byte address; bits [1:0] ignored.
- MemWrite  in  1  write request.
- Write_data  in  32  write data, byte lanes already positioned.
- Write_strb  in  4  byte enables; bit i enables Write_data[8i+7:8i].
- MemRead  in  1  read request.
- Mem_Req_Ready  out  1  data request accepted this cycle if MemRead or MemWrite.
- Read_data  out  32  full read word; the core does lane extraction.
- Read_data_Valid  out  1  read response valid.
- Read_data_Ready  in  1  core accepts the read response.

## Operation
- Instruction FSM has three states:
  - I_IDLE: Inst_Req_Ready=1. If Inst_Req_Valid, latch the word address and load the latency counter. Go to I_WAIT, or straight to I_RESP when INST_LATENCY=1.
  - I_WAIT: decrement the counter. On expiry, capture RAM[word] into Instruction and go to I_RESP.
  - I_RESP: Inst_Valid=1. Instruction is stable. On Inst_Ready, go to I_IDLE.
- Data FSM has three states:
  - D_IDLE: Mem_Req_Ready=1.
    - MemWrite: commit enabled bytes at this edge and stay in D_IDLE. No response is generated.
    - MemRead with MemWrite=0: latch the address and go to D_WAIT, or straight to D_RESP when DATA_LATENCY=1.
    - MemRead and MemWrite both high: treated as a write only.
  - D_WAIT: count down. On expiry, capture the RAM word into Read_data and go to D_RESP.
  - D_RESP: Read_data_Valid=1. Read_data is stable. On Read_data_Ready, go to D_IDLE.
- Request inputs outside the IDLE states are ignored. Write_strb=0000 is an accepted write that changes nothing.
- The two FSMs are independent and may both be busy at once. The instruction port is read-only.
- Read-during-write: a response captured at the same edge as a write to the same word returns the old value. A read captured at any later edge sees the new bytes.
- RAM contents are not reset and are preserved across reset. Writes are suppressed while rst=0.

## Timing
- While rst=0, and in the first cycle after release:
  - Both FSMs are in IDLE.
  - Inst_Valid=0, Read_data_Valid=0, Instruction=0, Read_data=0.
- Inst_Req_Ready and Mem_Req_Ready are forced 0 while rst=0. They read 1 in the first cycle with rst=1.
- Readies depend only on state, never combinationally on the request valids.
- If the request handshake occurs in cycle c, the valid output is first high in cycle c+LATENCY.
- If the response handshake occurs in cycle r:
  - valid is 0 in cycle r+1;
  - the request ready is 1 in cycle r+1;
  - the earliest next request handshake is cycle r+1.
- A response with ready held high lasts exactly one cycle. A response is held indefinitely while ready is low.
- Back-to-back writes are accepted every cycle.
- Reset asserted mid-transaction aborts it in the next cycle with no response. An in-flight write that was already handshaked is kept.

## Test plan
- Write and readback:
  - Stimulus: after reset, write 0xDEADBEEF with strb 1111 to 0x100, then read 0x100 with Read_data_Ready=1.
  - Required: Read_data_Valid rises exactly DATA_LATENCY cycles after the read handshake, Read_data=0xDEADBEEF, valid lasts one cycle.
- Byte strobes:
  - Stimulus: word 0x100 holds 0xDEADBEEF. Write Write_data=0x00AA0000 with strb 0100, then read 0x103.
  - Required: Read_data=0xDEAABEEF, showing address bits [1:0] are ignored.
- Response backpressure:
  - Stimulus: instruction fetch at PC=0x100 with Inst_Ready held low for 5 cycles.
  - Required: Inst_Valid=1 and Instruction=0xDEAABEEF stable for all 5 cycles; Inst_Req_Ready=0 throughout.
  - Required: after Inst_Ready rises, Inst_Req_Ready=1 on the next cycle.
- Concurrency:
  - Stimulus: data read of 0x100 and instruction fetch of 0x100 handshaked in the same cycle, with INST_LATENCY=3 and DATA_LATENCY=1.
  - Required: Read_data_Valid one cycle after the handshake, Inst_Valid three cycles after, both returning the same word.
- Read-during-write:
  - Stimulus: a write to word W commits at the same edge an instruction response for W is captured.
  - Required: Instruction returns the old value; a following fetch of W returns the new value.
- Reset mid-read:
  - Stimulus: drive rst=0 during D_WAIT.
  - Required: Read_data_Valid never asserts; Mem_Req_Ready is 0 during reset and 1 in the first cycle after release; previously written RAM contents are intact.

Source files
------------

// File: rtl/cpu_mem_responder_if.sv
// Core <-> memory channel bundle: instruction fetch and data load/store.
// master = core side, slave = memory responder side.
interface cpu_mem_responder_if;
  // instruction request / response
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  // data request / response
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  modport master (
    output PC,
    output Inst_Req_Valid,
    input  Inst_Req_Ready,
    input  Instruction,
    input  Inst_Valid,
    output Inst_Ready,
    output Address,
    output MemWrite,
    output Write_data,
    output Write_strb,
    output MemRead,
    input  Mem_Req_Ready,
    input  Read_data,
    input  Read_data_Valid,
    output Read_data_Ready
  );

  modport slave (
    input  PC,
    input  Inst_Req_Valid,
    output Inst_Req_Ready,
    output Instruction,
    output Inst_Valid,
    input  Inst_Ready,
    input  Address,
    input  MemWrite,
    input  Write_data,
    input  Write_strb,
    input  MemRead,
    output Mem_Req_Ready,
    output Read_data,
    output Read_data_Valid,
    input  Read_data_Ready
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Word RAM answering the core's instruction and data channels with
// fixed latency. Ports: clk, rst (sync, active-low), bus (slave).
module cpu_mem_responder #(
  parameter int ADDR_WIDTH   = 12,
  parameter int INST_LATENCY = 2,
  parameter int DATA_LATENCY = 2
) (
  input logic            clk,
  input logic            rst,
  cpu_mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = 16;

  localparam logic [CW-1:0] ILOAD = CW'(INST_LATENCY - 1);
  localparam logic [CW-1:0] DLOAD = CW'(DATA_LATENCY - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {
    I_IDLE,
    I_WAIT,
    I_RESP
  } i_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_WAIT,
    D_RESP
  } d_state_t;

  // storage: not reset, survives rst
  logic [31:0] r_mem [DEPTH];

  i_state_t        r_istate;
  i_state_t        w_istate_nxt;
  logic [CW-1:0]   r_icnt;
  logic [CW-1:0]   w_icnt_nxt;
  logic [ADDR_WIDTH-1:0] r_iaddr;
  logic [ADDR_WIDTH-1:0] w_iaddr_nxt;
  logic [ADDR_WIDTH-1:0] w_icap_addr;
  logic            w_icap;
  logic            w_ireq_rdy;
  logic [31:0]     r_inst;

  d_state_t        r_dstate;
  d_state_t        w_dstate_nxt;
  logic [CW-1:0]   r_dcnt;
  logic [CW-1:0]   w_dcnt_nxt;
  logic [ADDR_WIDTH-1:0] r_daddr;
  logic [ADDR_WIDTH-1:0] w_daddr_nxt;
  logic [ADDR_WIDTH-1:0] w_dcap_addr;
  logic            w_dcap;
  logic            w_dreq_rdy;
  logic            w_dwr;
  logic            w_we;
  logic [31:0]     r_rdata;

  logic [ADDR_WIDTH-1:0] w_pc_word;
  logic [ADDR_WIDTH-1:0] w_ad_word;
  logic            w_unused;

  assign w_pc_word = bus.PC[ADDR_WIDTH+1:2];
  assign w_ad_word = bus.Address[ADDR_WIDTH+1:2];

  // upper address bits wrap; low two select a byte the core handles
  assign w_unused = ^{bus.PC[31:ADDR_WIDTH+2], bus.PC[1:0],
                      bus.Address[31:ADDR_WIDTH+2],
                      bus.Address[1:0]};

  // ---------------- instruction FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_istate <= I_IDLE;
      r_icnt   <= '0;
      r_iaddr  <= '0;
    end else begin
      r_istate <= w_istate_nxt;
      r_icnt   <= w_icnt_nxt;
      r_iaddr  <= w_iaddr_nxt;
    end
  end

  always_comb begin
    w_istate_nxt = r_istate;
    w_icnt_nxt   = r_icnt;
    w_iaddr_nxt  = r_iaddr;
    w_icap       = 1'b0;
    w_icap_addr  = r_iaddr;
    w_ireq_rdy   = 1'b0;
    unique case (r_istate)
      I_IDLE: begin
        w_ireq_rdy = 1'b1;
        if (bus.Inst_Req_Valid) begin
          w_iaddr_nxt = w_pc_word;
          w_icnt_nxt  = ILOAD;
          if (INST_LATENCY == 1) begin
            // single-cycle latency: sample RAM at the request edge
            w_icap       = 1'b1;
            w_icap_addr  = w_pc_word;
            w_istate_nxt = I_RESP;
          end else begin
            w_istate_nxt = I_WAIT;
          end
        end
      end
      I_WAIT: begin
        w_icnt_nxt = r_icnt - ONE;
        if (r_icnt == ONE) begin
          w_icap       = 1'b1;
          w_istate_nxt = I_RESP;
        end
      end
      I_RESP: begin
        if (bus.Inst_Ready) begin
          w_istate_nxt = I_IDLE;
        end
      end
      default: begin
        w_istate_nxt = I_IDLE;
      end
    endcase
  end

  // ---------------- data FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dstate <= D_IDLE;
      r_dcnt   <= '0;
      r_daddr  <= '0;
    end else begin
      r_dstate <= w_dstate_nxt;
      r_dcnt   <= w_dcnt_nxt;
      r_daddr  <= w_daddr_nxt;
    end
  end

  always_comb begin
    w_dstate_nxt = r_dstate;
    w_dcnt_nxt   = r_dcnt;
    w_daddr_nxt  = r_daddr;
    w_dcap       = 1'b0;
    w_dcap_addr  = r_daddr;
    w_dreq_rdy   = 1'b0;
    w_dwr        = 1'b0;
    unique case (r_dstate)
      D_IDLE: begin
        w_dreq_rdy = 1'b1;
        if (bus.MemWrite) begin
          // write wins over a simultaneous read; no response
          w_dwr = 1'b1;
        end else if (bus.MemRead) begin
          w_daddr_nxt = w_ad_word;
          w_dcnt_nxt  = DLOAD;
          if (DATA_LATENCY == 1) begin
            w_dcap       = 1'b1;
            w_dcap_addr  = w_ad_word;
            w_dstate_nxt = D_RESP;
          end else begin
            w_dstate_nxt = D_WAIT;
          end
        end
      end
      D_WAIT: begin
        w_dcnt_nxt = r_dcnt - ONE;
        if (r_dcnt == ONE) begin
          w_dcap       = 1'b1;
          w_dstate_nxt = D_RESP;
        end
      end
      D_RESP: begin
        if (bus.Read_data_Ready) begin
          w_dstate_nxt = D_IDLE;
        end
      end
      default: begin
        w_dstate_nxt = D_IDLE;
      end
    endcase
  end

  // ---------------- RAM and response capture ----------------
  assign w_we = rst & w_dwr;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.Write_strb[b]) begin
          r_mem[w_ad_word][8*b +: 8] <= bus.Write_data[8*b +: 8];
        end
      end
    end
  end

  // captures read pre-edge RAM, so a same-edge write returns old data
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inst  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_icap) begin
        r_inst <= r_mem[w_icap_addr];
      end
      if (w_dcap) begin
        r_rdata <= r_mem[w_dcap_addr];
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.Inst_Req_Ready  = rst & w_ireq_rdy;
  assign bus.Mem_Req_Ready   = rst & w_dreq_rdy;
  assign bus.Inst_Valid      = rst & (r_istate == I_RESP);
  assign bus.Read_data_Valid = rst & (r_dstate == D_RESP);
  assign bus.Instruction     = r_inst;
  assign bus.Read_data       = r_rdata;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: two latency configurations, a
// cycle-level reference model, and directed scenario checks.
module tb_cpu_mem_responder;

  localparam int IL0 = 3;
  localparam int DL0 = 1;
  localparam int IL1 = 1;
  localparam int DL1 = 2;

  int il[2] = '{IL0, IL1};
  int dl[2] = '{DL0, DL1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc    = '0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  strb  = '0;
  logic ireq = 1'b0;
  logic irdy = 1'b1;
  logic mw   = 1'b0;
  logic mr   = 1'b0;
  logic rrdy = 1'b1;

  cpu_mem_responder_if if0 ();
  cpu_mem_responder_if if1 ();

  assign if0.PC = pc;
  assign if0.Inst_Req_Valid = ireq;
  assign if0.Inst_Ready = irdy;
  assign if0.Address = addr;
  assign if0.MemWrite = mw;
  assign if0.Write_data = wdata;
  assign if0.Write_strb = strb;
  assign if0.MemRead = mr;
  assign if0.Read_data_Ready = rrdy;

  assign if1.PC = pc;
  assign if1.Inst_Req_Valid = ireq;
  assign if1.Inst_Ready = irdy;
  assign if1.Address = addr;
  assign if1.MemWrite = mw;
  assign if1.Write_data = wdata;
  assign if1.Write_strb = strb;
  assign if1.MemRead = mr;
  assign if1.Read_data_Ready = rrdy;

  cpu_mem_responder #(
    .ADDR_WIDTH(12), .INST_LATENCY(IL0), .DATA_LATENCY(DL0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );

  cpu_mem_responder #(
    .ADDR_WIDTH(12), .INST_LATENCY(IL1), .DATA_LATENCY(DL1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  logic        o_irr [2];
  logic        o_mrr [2];
  logic        o_iv  [2];
  logic        o_rv  [2];
  logic [31:0] o_ins [2];
  logic [31:0] o_rd  [2];

  always_comb begin
    o_irr[0] = if0.Inst_Req_Ready;
    o_mrr[0] = if0.Mem_Req_Ready;
    o_iv[0]  = if0.Inst_Valid;
    o_rv[0]  = if0.Read_data_Valid;
    o_ins[0] = if0.Instruction;
    o_rd[0]  = if0.Read_data;
    o_irr[1] = if1.Inst_Req_Ready;
    o_mrr[1] = if1.Mem_Req_Ready;
    o_iv[1]  = if1.Inst_Valid;
    o_rv[1]  = if1.Read_data_Valid;
    o_ins[1] = if1.Instruction;
    o_rd[1]  = if1.Read_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, int k, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h at %0t",
               nm, k, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel: busy from request to response handshake; the
  // response word is sampled from the RAM image at the edge that
  // opens cycle (request cycle + latency).
  longint      cyc = 0;
  bit          m_ib [2] = '{0, 0};
  bit          m_iv [2] = '{0, 0};
  bit          m_db [2] = '{0, 0};
  bit          m_dv [2] = '{0, 0};
  longint      m_idue [2];
  longint      m_ddue [2];
  logic [11:0] m_ia [2];
  logic [11:0] m_da [2];
  logic [31:0] m_iw [2];
  logic [31:0] m_dw [2];
  logic [31:0] mm [2][4096];

  function automatic logic [31:0] merge(logic [31:0] o,
                                        logic [31:0] d,
                                        logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_ib[k] <= 0;
        m_iv[k] <= 0;
        m_db[k] <= 0;
        m_dv[k] <= 0;
      end else begin
        if (!m_ib[k]) begin
          if (ireq) begin
            m_ib[k]   <= 1;
            m_ia[k]   <= pc[13:2];
            m_idue[k] <= cyc + il[k];
            if (cyc + il[k] == cyc + 1) begin
              m_iv[k] <= 1;
              m_iw[k] <= mm[k][pc[13:2]];
            end
          end
        end else if (m_iv[k]) begin
          if (irdy) begin
            m_ib[k] <= 0;
            m_iv[k] <= 0;
          end
        end else if (cyc + 1 == m_idue[k]) begin
          m_iv[k] <= 1;
          m_iw[k] <= mm[k][m_ia[k]];
        end

        if (!m_db[k]) begin
          if (mw) begin
            mm[k][addr[13:2]] <= merge(mm[k][addr[13:2]], wdata, strb);
          end else if (mr) begin
            m_db[k]   <= 1;
            m_da[k]   <= addr[13:2];
            m_ddue[k] <= cyc + dl[k];
            if (cyc + dl[k] == cyc + 1) begin
              m_dv[k] <= 1;
              m_dw[k] <= mm[k][addr[13:2]];
            end
          end
        end else if (m_dv[k]) begin
          if (rrdy) begin
            m_db[k] <= 0;
            m_dv[k] <= 0;
          end
        end else if (cyc + 1 == m_ddue[k]) begin
          m_dv[k] <= 1;
          m_dw[k] <= mm[k][m_da[k]];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("m_inst_req_ready", k, o_irr[k], rst && !m_ib[k]);
      chk("m_mem_req_ready", k, o_mrr[k], rst && !m_db[k]);
      chk("m_inst_valid", k, o_iv[k], rst && m_iv[k]);
      chk("m_read_valid", k, o_rv[k], rst && m_dv[k]);
      if (rst && m_iv[k]) chk("m_instruction", k, o_ins[k], m_iw[k]);
      if (rst && m_dv[k]) chk("m_read_data", k, o_rd[k], m_dw[k]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while (!(o_irr[0] && o_irr[1] && o_mrr[0] && o_mrr[1])) begin
      if (n == 30) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout got busy want idle at %0t", $time);
        return;
      end
      n++;
      tick();
    end
  endtask

  task automatic write_w(logic [31:0] a, logic [31:0] d,
                         logic [3:0] s);
    wait_idle();
    addr = a; wdata = d; strb = s; mw = 1'b1;
    tick();
    mw = 1'b0;
  endtask

  task automatic read_chk(string nm, logic [31:0] a, logic [31:0] e);
    wait_idle();
    addr = a; mr = 1'b1;
    tick();
    mr = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk({nm, "_rvalid"}, k, o_rv[k], t == dl[k]);
        if (t == dl[k]) chk({nm, "_rdata"}, k, o_rd[k], e);
      end
    end
  endtask

  task automatic fetch_chk(string nm, logic [31:0] a, logic [31:0] e);
    wait_idle();
    pc = a; ireq = 1'b1;
    tick();
    ireq = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk({nm, "_ivalid"}, k, o_iv[k], t == il[k]);
        if (t == il[k]) chk({nm, "_inst"}, k, o_ins[k], e);
      end
    end
  endtask

  logic [31:0] rdw_exp [2] = '{32'h2222_2222, 32'h1111_1111};

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_irr", k, o_irr[k], 0);
      chk("rst_mrr", k, o_mrr[k], 0);
      chk("rst_iv", k, o_iv[k], 0);
      chk("rst_rv", k, o_rv[k], 0);
      chk("rst_ins", k, o_ins[k], 0);
      chk("rst_rd", k, o_rd[k], 0);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rel_irr", k, o_irr[k], 1);
      chk("rel_mrr", k, o_mrr[k], 1);
      chk("rel_iv", k, o_iv[k], 0);
      chk("rel_ins", k, o_ins[k], 0);
      chk("rel_rd", k, o_rd[k], 0);
    end

    // back-to-back writes, then readback
    tick();
    addr = 32'h100; wdata = 32'hDEAD_BEEF; strb = 4'hF; mw = 1'b1;
    tick();
    addr = 32'h200; wdata = 32'h1111_1111;
    tick();
    mw = 1'b0;
    read_chk("wr_rd", 32'h100, 32'hDEAD_BEEF);
    read_chk("wr_rd2", 32'h200, 32'h1111_1111);

    // byte strobe, unaligned read address
    write_w(32'h100, 32'h00AA_0000, 4'b0100);
    read_chk("strb", 32'h103, 32'hDEAA_BEEF);

    // response backpressure
    wait_idle();
    irdy = 1'b0;
    pc = 32'h100; ireq = 1'b1;
    tick();
    ireq = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("bp_iv", k, o_iv[k], 1);
        chk("bp_ins", k, o_ins[k], 32'hDEAA_BEEF);
        chk("bp_irr", k, o_irr[k], 0);
      end
      tick();
    end
    irdy = 1'b1;
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("bp_rel_iv", k, o_iv[k], 0);
      chk("bp_rel_irr", k, o_irr[k], 1);
    end

    // concurrent fetch and read of the same word
    wait_idle();
    pc = 32'h100; addr = 32'h100; ireq = 1'b1; mr = 1'b1;
    tick();
    ireq = 1'b0; mr = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("cc_rv", k, o_rv[k], t == dl[k]);
        chk("cc_iv", k, o_iv[k], t == il[k]);
        if (t == dl[k]) chk("cc_rd", k, o_rd[k], 32'hDEAA_BEEF);
        if (t == il[k]) chk("cc_ins", k, o_ins[k], 32'hDEAA_BEEF);
      end
    end

    // read-during-write on the instruction port
    wait_idle();
    pc = 32'h200; ireq = 1'b1;
    addr = 32'h200; wdata = 32'h2222_2222; strb = 4'hF; mw = 1'b1;
    tick();
    ireq = 1'b0; mw = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("rdw_iv", k, o_iv[k], t == il[k]);
        if (t == il[k]) chk("rdw_ins", k, o_ins[k], rdw_exp[k]);
      end
      tick();
      if (t == 1) begin
        wdata = 32'h3333_3333; mw = 1'b1;
      end else begin
        mw = 1'b0;
      end
    end
    fetch_chk("rdw_new", 32'h200, 32'h3333_3333);

    // reset in the middle of a read
    wait_idle();
    addr = 32'h100; mr = 1'b1;
    tick();
    mr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("mid_mrr0", k, o_mrr[k], 0);
    tick();
    addr = 32'h100; wdata = 32'h0; strb = 4'hF; mw = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("mid_mrr1", k, o_mrr[k], 0);
      chk("mid_rv1", k, o_rv[k], 0);
    end
    tick();
    mw = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("mid_rel_mrr", k, o_mrr[k], 1);
      chk("mid_rel_rv", k, o_rv[k], 0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk("mid_no_rv", k, o_rv[k], 0);
    end

    // zero-strobe write changes nothing; contents survive reset
    write_w(32'h100, 32'hFFFF_FFFF, 4'h0);
    read_chk("keep100", 32'h100, 32'hDEAA_BEEF);
    read_chk("keep200", 32'h200, 32'h3333_3333);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
